// File: rtl/clk_div_monitor.sv
// Clock-divider monitor: measures every half-period of a divided clock and
// declares lock after a run of in-tolerance halves, flagging mismatches and stalls.
module clk_div_monitor #(
  parameter int HALF_PERIOD = 4,
  parameter int TOL         = 0,
  parameter int LOCK_N      = 4,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             div_in_i,
  input  logic             clr_err_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] meas_half_o,
  output logic [7:0]       err_cnt_o
);

  localparam int               GR_W       = $clog2(LOCK_N + 1);
  localparam int               MATCH_LO_I = (HALF_PERIOD > TOL) ? HALF_PERIOD - TOL : 0;
  localparam logic [CNT_W-1:0] MATCH_LO   = CNT_W'(MATCH_LO_I);
  localparam logic [CNT_W-1:0] MATCH_HI   = CNT_W'(HALF_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [GR_W-1:0]  LOCK_C     = GR_W'(LOCK_N);

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [GR_W-1:0]   goodRun_q, goodRun_d;
  logic              divSync_q;
  logic [CNT_W-1:0]  halfCnt_q;
  logic [CNT_W-1:0]  measHalf_q;
  logic              errPulse_q;
  logic              errSticky_q;
  logic [7:0]        errCnt_q;

  logic edgeDet;
  logic match;
  logic timeoutHit;
  logic errDet;

  // A stalled div_in only counts as a timeout when no edge arrives that same cycle.
  assign edgeDet    = en_i && (div_in_i != divSync_q);
  assign match      = (halfCnt_q >= MATCH_LO) && (halfCnt_q <= MATCH_HI);
  assign timeoutHit = en_i && !edgeDet && (halfCnt_q == TIMEOUT_C);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ACQ;
      goodRun_q <= '0;
    end else begin
      state_q   <= state_d;
      goodRun_q <= goodRun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    goodRun_d = goodRun_q;
    errDet    = 1'b0;
    unique case (state_q)
      ACQ: begin
        if (edgeDet) begin
          state_d   = TRACK;
          goodRun_d = '0;
        end
      end
      TRACK, LOCKED: begin
        if (edgeDet) begin
          if (!match) begin
            errDet    = 1'b1;
            goodRun_d = '0;
            state_d   = TRACK;
          end else if (state_q == TRACK) begin
            goodRun_d = goodRun_q + GR_W'(1);
            if (goodRun_d == LOCK_C) state_d = LOCKED;
          end
        end else if (timeoutHit) begin
          errDet    = 1'b1;
          goodRun_d = '0;
          state_d   = ACQ;
        end
      end
      default: begin
        state_d   = ACQ;
        goodRun_d = '0;
      end
    endcase
    // Disabling the monitor discards the measurement in progress.
    if (!en_i) begin
      state_d   = ACQ;
      goodRun_d = '0;
      errDet    = 1'b0;
    end
  end

  always_comb begin
    locked_o     = (state_q == LOCKED);
    err_pulse_o  = errPulse_q;
    err_sticky_o = errSticky_q;
    meas_half_o  = measHalf_q;
    err_cnt_o    = errCnt_q;
  end

  // A new error takes priority over a simultaneous clear request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      divSync_q   <= 1'b0;
      halfCnt_q   <= '0;
      measHalf_q  <= '0;
      errPulse_q  <= 1'b0;
      errSticky_q <= 1'b0;
      errCnt_q    <= '0;
    end else begin
      divSync_q <= div_in_i;
      if (!en_i) begin
        halfCnt_q <= '0;
      end else if (edgeDet) begin
        halfCnt_q <= CNT_W'(1);
      end else if (halfCnt_q != CNT_MAX) begin
        halfCnt_q <= halfCnt_q + CNT_W'(1);
      end
      if (edgeDet) measHalf_q <= halfCnt_q;
      errPulse_q <= errDet;
      if (errDet) begin
        errSticky_q <= 1'b1;
        if (clr_err_i)              errCnt_q <= 8'd1;
        else if (errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
      end else if (clr_err_i) begin
        errSticky_q <= 1'b0;
        errCnt_q    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: two instances (TOL=0 and TOL=1) share stimulus and are
// compared each cycle against an interval-based model plus directed scenario checks.
module tb_clk_div_monitor;

  localparam int HP = 4;
  localparam int TO = 16;
  localparam int LN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, div_in, clr_err;
  logic       locked0, locked1, pulse0, pulse1, sticky0, sticky1;
  logic [7:0] meas0, meas1, cnt0, cnt1;
  logic [18:0] obs0, obs1;

  assign obs0 = {locked0, pulse0, sticky0, meas0, cnt0};
  assign obs1 = {locked1, pulse1, sticky1, meas1, cnt1};

  clk_div_monitor #(.HALF_PERIOD(HP), .TOL(0), .LOCK_N(LN), .TIMEOUT(TO), .CNT_W(8)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .div_in_i(div_in), .clr_err_i(clr_err),
    .locked_o(locked0), .err_pulse_o(pulse0), .err_sticky_o(sticky0),
    .meas_half_o(meas0), .err_cnt_o(cnt0));

  clk_div_monitor #(.HALF_PERIOD(HP), .TOL(1), .LOCK_N(LN), .TIMEOUT(TO), .CNT_W(8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .div_in_i(div_in), .clr_err_i(clr_err),
    .locked_o(locked1), .err_pulse_o(pulse1), .err_sticky_o(sticky1),
    .meas_half_o(meas1), .err_cnt_o(cnt1));

  int nVec = 0;
  int nErr = 0;
  int cycNo = 0;
  logic divLvl = 1'b0;

  // Model: time of the last edge (base), acquisition flag and run of consecutive good halves.
  int mBase[2];
  bit mAcq[2];
  int mRun[2];
  int mMeas[2];
  int mCnt[2];
  bit mSticky[2];
  bit mPulse[2];
  bit mDivQ[2];

  function automatic void modelStep(int i);
    int h;
    bit edgeSeen, err;
    int tol;
    tol = (i == 0) ? 0 : 1;
    if (!rst_n) begin
      mDivQ[i] = 0; mBase[i] = cycNo; mAcq[i] = 1; mRun[i] = 0;
      mMeas[i] = 0; mCnt[i] = 0; mSticky[i] = 0; mPulse[i] = 0;
      return;
    end
    h = cycNo - 1 - mBase[i];
    if (h > 255) h = 255;
    edgeSeen = en && (div_in != mDivQ[i]);
    mDivQ[i] = div_in;
    err = 0;
    if (!en) begin
      mAcq[i] = 1; mRun[i] = 0; mBase[i] = cycNo;
    end else if (edgeSeen) begin
      mMeas[i] = h;
      if (mAcq[i]) begin
        mAcq[i] = 0; mRun[i] = 0;
      end else if ((h - HP <= tol) && (HP - h <= tol)) begin
        mRun[i]++;
      end else begin
        err = 1; mRun[i] = 0;
      end
      mBase[i] = cycNo - 1;
    end else if (!mAcq[i] && h == TO) begin
      err = 1; mAcq[i] = 1; mRun[i] = 0;
    end
    mPulse[i] = err;
    if (err) begin
      mSticky[i] = 1;
      mCnt[i] = clr_err ? 1 : ((mCnt[i] < 255) ? mCnt[i] + 1 : 255);
    end else if (clr_err) begin
      mSticky[i] = 0; mCnt[i] = 0;
    end
  endfunction

  function automatic logic [18:0] expVec(int i);
    logic lk;
    lk = !mAcq[i] && (mRun[i] >= LN);
    return {lk, mPulse[i], mSticky[i], 8'(mMeas[i]), 8'(mCnt[i])};
  endfunction

  task automatic cyc(input logic r, input logic e, input logic d, input logic c);
    rst_n = r; en = e; div_in = d; clr_err = c;
    @(posedge clk);
    cycNo++;
    modelStep(0);
    modelStep(1);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nVec++;
      if (obs0 !== 19'd0 || obs1 !== 19'd0) begin
        nErr++;
        $display("[TB] FAIL reset_state: got %h/%h required 0/0", obs0, obs1);
      end
    end
  endtask

  task automatic test_lock(input int rstCycles);
    int edges;
    divLvl = 1'b0;
    for (int k = 0; k < rstCycles; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      nVec++;
      if (obs0 !== 19'd0) begin
        nErr++;
        $display("[TB] FAIL reset_outputs: got %h required 0", obs0);
      end
    end
    edges = 0;
    for (int i = 0; i < 44; i++) begin
      if (i >= 10 && (i - 10) % 4 == 0) begin
        divLvl = ~divLvl;
        edges++;
      end
      cyc(1'b1, 1'b1, divLvl, 1'b0);
      nVec++;
      if (obs0 !== expVec(0)) begin
        nErr++;
        $display("[TB] FAIL lock_seq cycle %0d: got %h required %h", i, obs0, expVec(0));
      end
      if (i == 22) begin
        nVec++;
        if (locked0 !== 1'b0) begin
          nErr++;
          $display("[TB] FAIL lock_early: locked=%b required 0 after edge 4", locked0);
        end
      end
      if (i == 26) begin
        nVec++;
        if (locked0 !== 1'b1 || meas0 !== 8'd4 || cnt0 !== 8'd0) begin
          nErr++;
          $display("[TB] FAIL lock_rise: locked=%b meas=%0d cnt=%0d required 1/4/0", locked0, meas0, cnt0);
        end
      end
    end
  endtask

  task automatic test_stretch();
    int lens[7] = '{4, 5, 4, 4, 4, 4, 4};
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, divLvl, 1'b0);
      nVec++;
      if (obs0 !== expVec(0)) begin
        nErr++;
        $display("[TB] FAIL stretch_pre: got %h required %h", obs0, expVec(0));
      end
    end
    for (int h = 0; h < 7; h++) begin
      for (int j = 0; j < lens[h]; j++) begin
        if (j == 0) divLvl = ~divLvl;
        cyc(1'b1, 1'b1, divLvl, 1'b0);
        nVec++;
        if (obs0 !== expVec(0)) begin
          nErr++;
          $display("[TB] FAIL stretch_seq h%0d j%0d: got %h required %h", h, j, obs0, expVec(0));
        end
        if (h == 2 && j == 0) begin
          nVec++;
          if (pulse0 !== 1'b1 || meas0 !== 8'd5 || locked0 !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL stretch_err: pulse=%b meas=%0d locked=%b required 1/5/0", pulse0, meas0, locked0);
          end
        end
        if (h == 2 && j == 1) begin
          nVec++;
          if (pulse0 !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL stretch_pulse_width: pulse=%b required 0", pulse0);
          end
        end
        if (j == 0 && (h == 5 || h == 6)) begin
          nVec++;
          if (locked0 !== (h == 6)) begin
            nErr++;
            $display("[TB] FAIL stretch_relock h%0d: locked=%b required %b", h, locked0, h == 6);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int pulseAt = -1;
    for (int j = 0; j < 40; j++) begin
      if (j == 0) divLvl = ~divLvl;
      cyc(1'b1, 1'b1, divLvl, 1'b0);
      nVec++;
      if (obs0 !== expVec(0)) begin
        nErr++;
        $display("[TB] FAIL timeout_seq j%0d: got %h required %h", j, obs0, expVec(0));
      end
      if (pulse0 === 1'b1) begin
        pulses++;
        pulseAt = j;
      end
    end
    nVec++;
    if (pulses !== 1 || pulseAt !== TO || locked0 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL timeout_pulse: pulses=%0d at=%0d locked=%b required 1 at %0d, 0", pulses, pulseAt, locked0, TO);
    end
  endtask

  task automatic test_enable();
    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 0) divLvl = ~divLvl;
      cyc(1'b1, 1'b1, divLvl, 1'b0);
    end
    nVec++;
    if (locked0 !== 1'b1) begin
      nErr++;
      $display("[TB] FAIL enable_prelock: locked=%b required 1", locked0);
    end
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) divLvl = ~divLvl;
      cyc(1'b1, 1'b0, divLvl, 1'b0);
      nVec++;
      if (locked0 !== 1'b0 || pulse0 !== 1'b0 || meas0 !== 8'd4 || obs0 !== expVec(0)) begin
        nErr++;
        $display("[TB] FAIL enable_low k%0d: got %h required %h (meas 4, unlocked, no pulse)", k, obs0, expVec(0));
      end
    end
    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 0) divLvl = ~divLvl;
      cyc(1'b1, 1'b1, divLvl, 1'b0);
      nVec++;
      if (obs0 !== expVec(0)) begin
        nErr++;
        $display("[TB] FAIL enable_resume k%0d: got %h required %h", k, obs0, expVec(0));
      end
    end
  endtask

  task automatic test_tolerance();
    int p0 = 0;
    int p1 = 0;
    int len;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    divLvl = 1'b0;
    for (int h = 0; h < 12; h++) begin
      len = (h % 2 == 0) ? 3 : 5;
      for (int j = 0; j < len; j++) begin
        if (j == 0) divLvl = ~divLvl;
        cyc(1'b1, 1'b1, divLvl, 1'b0);
        nVec++;
        if (obs0 !== expVec(0) || obs1 !== expVec(1)) begin
          nErr++;
          $display("[TB] FAIL tol_seq h%0d: got %h/%h required %h/%h", h, obs0, obs1, expVec(0), expVec(1));
        end
        p0 += (pulse0 === 1'b1) ? 1 : 0;
        p1 += (pulse1 === 1'b1) ? 1 : 0;
      end
    end
    nVec++;
    if (p0 !== 11 || cnt0 !== 8'd11 || p1 !== 0 || cnt1 !== 8'd0 || locked1 !== 1'b1) begin
      nErr++;
      $display("[TB] FAIL tol_result: p0=%0d cnt0=%0d p1=%0d cnt1=%0d locked1=%b required 11/11/0/0/1",
               p0, cnt0, p1, cnt1, locked1);
    end
  endtask

  task automatic test_saturate();
    int len;
    for (int h = 0; h < 300; h++) begin
      len = (h % 2 == 0) ? 3 : 5;
      for (int j = 0; j < len; j++) begin
        if (j == 0) divLvl = ~divLvl;
        cyc(1'b1, 1'b1, divLvl, 1'b0);
      end
    end
    nVec++;
    if (cnt0 !== 8'd255 || sticky0 !== 1'b1 || obs0 !== expVec(0)) begin
      nErr++;
      $display("[TB] FAIL sat_cnt: cnt=%0d sticky=%b required 255/1", cnt0, sticky0);
    end
    divLvl = ~divLvl;
    cyc(1'b1, 1'b1, divLvl, 1'b1);
    nVec++;
    if (cnt0 !== 8'd1 || sticky0 !== 1'b1 || pulse0 !== 1'b1) begin
      nErr++;
      $display("[TB] FAIL clr_vs_err: cnt=%0d sticky=%b pulse=%b required 1/1/1", cnt0, sticky0, pulse0);
    end
    cyc(1'b1, 1'b1, divLvl, 1'b1);
    nVec++;
    if (cnt0 !== 8'd0 || sticky0 !== 1'b0 || obs1 !== expVec(1)) begin
      nErr++;
      $display("[TB] FAIL clr_only: cnt=%0d sticky=%b required 0/0", cnt0, sticky0);
    end
  endtask

  task automatic test_random();
    int rem = 0;
    int r;
    logic rr, ee, cc;
    for (int k = 0; k < 3000; k++) begin
      if (rem == 0) begin
        divLvl = ~divLvl;
        r = $urandom_range(0, 9);
        rem = (r < 6) ? 4 : (r < 8) ? $urandom_range(3, 5) : $urandom_range(1, 25);
      end
      rem--;
      rr = ($urandom_range(0, 199) != 0);
      ee = ($urandom_range(0, 49) != 0);
      cc = ($urandom_range(0, 29) == 0);
      cyc(rr, ee, divLvl, cc);
      nVec++;
      if (obs0 !== expVec(0) || obs1 !== expVec(1)) begin
        nErr++;
        $display("[TB] FAIL random k%0d: got %h/%h required %h/%h", k, obs0, obs1, expVec(0), expVec(1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; div_in = 1'b0; clr_err = 1'b0;
    test_reset();
    test_lock(2);
    test_stretch();
    test_timeout();
    test_enable();
    test_lock(1);
    test_tolerance();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4, expected clk cycles per div_in level (high or low).
REQ-002 SHALL have parameter TOL, default 0, allowed +/- deviation in cycles of a measured half-period.
REQ-003 SHALL have parameter LOCK_N, default 4, consecutive matching half-periods required for lock.
REQ-004 SHALL have parameter TIMEOUT, default 16, cycles without an edge before a stall error; TIMEOUT > HALF_PERIOD+TOL.
REQ-005 SHALL have parameter CNT_W, default 8, width of the measurement counter; 2^CNT_W-1 >= TIMEOUT.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 en  input  1  monitor enable; low forces ACQ and clears measurement state.
REQ-009 div_in  input  1  divided clock under test, synchronous to clk.
REQ-010 clr_err  input  1  clears err_sticky and err_cnt.
REQ-011 locked  output  1  div_in period verified.
REQ-012 err_pulse  output  1  one-cycle pulse per detected error.
REQ-013 err_sticky  output  1  set on any error, held until clr_err or reset.
REQ-014 meas_half  output  CNT_W  last measured half-period length.
REQ-015 err_cnt  output  8  error count, saturating at 255.

Function
REQ-016 SHALL register div_in into div_q every cycle; edge = (div_in != div_q) while en=1.
REQ-017 SHALL keep half_cnt: on edge load 1; otherwise increment, saturating at 2^CNT_W-1.
REQ-018 On each edge SHALL latch meas_half <= half_cnt (edges 4 cycles apart give meas_half=4).
REQ-019 Match SHALL mean |half_cnt - HALF_PERIOD| <= TOL, evaluated at the edge.
REQ-020 SHALL implement states ACQ, TRACK, LOCKED; ACQ entered at reset and whenever en=0.
REQ-021 ACQ: first edge -> TRACK with good_run=0; first interval discarded, no comparison, no error.
REQ-022 TRACK: matching edge increments good_run; on LOCK_N-th consecutive match -> LOCKED.
REQ-023 TRACK/LOCKED: mismatching edge -> err_pulse, good_run=0, next state TRACK.
REQ-024 TRACK/LOCKED: half_cnt == TIMEOUT with no edge that cycle -> err_pulse once, next state ACQ.
REQ-025 locked SHALL be 1 exactly while state is LOCKED (registered; rises the cycle after the qualifying edge).
REQ-026 err_pulse SHALL be registered, high one cycle per error; err_sticky set same cycle; err_cnt increments same cycle.
REQ-027 clr_err and a new error in the same cycle: error wins (err_sticky=1, err_cnt=1).
REQ-028 en falling: next cycle state ACQ, locked=0, good_run=0, half_cnt=0; meas_half, err_sticky, err_cnt retained.
REQ-029 While en=0 no edges, errors or timeouts SHALL be detected; div_q still tracks div_in.

Reset
REQ-030 rst_n=0 at a clk edge SHALL force state ACQ, locked=0, err_pulse=0, err_sticky=0, err_cnt=0, meas_half=0, half_cnt=0, good_run=0, div_q=0.
REQ-031 Reset asserted mid-TRACK/LOCKED SHALL abandon the measurement; no error reported for the aborted interval.

Verification (defaults: HALF_PERIOD=4, TOL=0, LOCK_N=4, TIMEOUT=16)
REQ-032 div_in toggles every 4 cycles from cycle 10 -> locked rises the cycle after the 5th edge; meas_half=4; err_cnt=0.
REQ-033 Locked, one level stretched to 5 cycles -> one err_pulse, meas_half=5, locked=0, relock after 4 further good halves.
REQ-034 Locked, div_in held constant -> err_pulse 16 cycles after last edge, state ACQ, no further pulses while stuck.
REQ-035 TOL=1, halves alternating 3 and 5 -> lock without errors; with TOL=0 -> err_pulse on every compared edge.
REQ-036 300 errors then clr_err concurrent with an error -> err_cnt saturates at 255, then reads 1, err_sticky stays 1.
REQ-037 rst_n low 1 cycle while locked -> all outputs reset values next cycle; relock follows REQ-032 timing.
